// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use, memory wait, branch flush, mul/div sequencing.
// Latency: stall/flush/enable outputs are combinational; md_busy/hilo_we/md_err decode registered state.
// Backpressure: a pending data-memory access freezes the pipeline and overrides every other condition.
//
// Ports: clk, rst_n (async, active-low); hazard inputs dm2reg_E, rf_wa_E, rs_D, rt_D,
//   pc_src_M, dm_req_M, dm_ready; mul/div inputs md_op_D, md_start_E, md_is_div_E.
//   Outputs stall_F, stall_D, flush_D, flush_E, en_EM, en_MW, md_busy, hilo_we, md_err.
// Build option: define MULDIV_SEQ_EN for the multi-cycle mul/div sequencer (IDLE/BUSY/DONE).
//   Without it, mul/div is treated as a single-cycle unit and md_busy/md_err stay 0.
module hazard_stall_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dm2reg_E,
   input  logic [4:0] rf_wa_E,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic       pc_src_M,
   input  logic       dm_req_M,
   input  logic       dm_ready,
   input  logic       md_op_D,
   input  logic       md_start_E,
   input  logic       md_is_div_E,
   output logic       stall_F,
   output logic       stall_D,
   output logic       flush_D,
   output logic       flush_E,
   output logic       en_EM,
   output logic       en_MW,
   output logic       md_busy,
   output logic       hilo_we,
   output logic       md_err
);

   logic mem_wait;
   logic load_use;
   logic md_stall;
   logic start_ok;

   assign mem_wait = dm_req_M & ~dm_ready;
   // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
   assign load_use = dm2reg_E & (rf_wa_E != 5'd0) &
                     ((rf_wa_E == rs_D) | (rf_wa_E == rt_D));
   // A start is only real if the instruction actually advances out of EX.
   assign start_ok = md_start_E & ~mem_wait & ~pc_src_M;

   // Priority: memory wait > taken branch > load-use / HI-LO interlock.
   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      en_EM   = 1'b1;
      en_MW   = 1'b1;
      if (mem_wait) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         en_EM   = 1'b0;
         en_MW   = 1'b0;
      end else if (pc_src_M) begin
         flush_D = 1'b1;
         flush_E = 1'b1;
      end else if (load_use | md_stall) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         flush_E = 1'b1;
      end
   end

`ifdef MULDIV_SEQ_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_t;

   // Counter is loaded with latency-2: one cycle is spent entering BUSY, one in DONE.
   localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 2);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

   md_state_t  state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start_ok) begin
               cnt_d   = md_is_div_E ? DIV_LOAD : MUL_LOAD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Counts through memory waits; a new start here is a protocol error.
            if (md_start_E) err_d = 1'b1;
            if (cnt_q == 6'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 6'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign md_busy  = (state_q == BUSY);
   assign hilo_we  = (state_q == DONE);
   assign md_err   = err_q;
   assign md_stall = md_op_D & md_busy;
`else
   logic unused_ok;
   assign unused_ok = ^{clk, rst_n, md_op_D, md_is_div_E, 6'(MUL_CYCLES), 6'(DIV_CYCLES)};

   assign md_busy  = 1'b0;
   assign md_err   = 1'b0;
   assign hilo_we  = start_ok;
   assign md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dm2reg_E;
   logic [4:0] rf_wa_E, rs_D, rt_D;
   logic       pc_src_M, dm_req_M, dm_ready;
   logic       md_op_D, md_start_E, md_is_div_E;
   logic       stall_F, stall_D, flush_D, flush_E, en_EM, en_MW;
   logic       md_busy, hilo_we, md_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .dm2reg_E(dm2reg_E), .rf_wa_E(rf_wa_E), .rs_D(rs_D), .rt_D(rt_D),
      .pc_src_M(pc_src_M), .dm_req_M(dm_req_M), .dm_ready(dm_ready),
      .md_op_D(md_op_D), .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
      .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
      .en_EM(en_EM), .en_MW(en_MW),
      .md_busy(md_busy), .hilo_we(hilo_we), .md_err(md_err)
   );

   // {stall_F, stall_D, flush_D, flush_E, en_EM, en_MW, md_busy, hilo_we, md_err}
   logic [8:0] outs;
   assign outs = {stall_F, stall_D, flush_D, flush_E, en_EM, en_MW, md_busy, hilo_we, md_err};

   localparam logic [8:0] O_IDLE  = 9'b0000_11_000;
   localparam logic [8:0] O_STALL = 9'b1101_11_000;
   localparam logic [8:0] O_WAIT  = 9'b1100_00_000;
   localparam logic [8:0] O_FLUSH = 9'b0011_11_000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      dm2reg_E = 0; rf_wa_E = 0; rs_D = 0; rt_D = 0;
      pc_src_M = 0; dm_req_M = 0; dm_ready = 0;
      md_op_D = 0; md_start_E = 0; md_is_div_E = 0;
   endtask

   // Drive one cycle of hazard inputs after the edge, compare outputs mid-cycle.
   task automatic vec(input string tag, input logic ld, input logic [4:0] wa,
                      input logic [4:0] rs, input logic [4:0] rt, input logic pc,
                      input logic req, input logic rdy, input logic [8:0] exp);
      @(posedge clk); #1;
      clear_inputs();
      dm2reg_E = ld; rf_wa_E = wa; rs_D = rs; rt_D = rt;
      pc_src_M = pc; dm_req_M = req; dm_ready = rdy;
      @(negedge clk);
      check(tag, 32'(outs), 32'(exp));
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #12;
      check("reset_outs", 32'(outs), 32'(O_IDLE));
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use hazards
      vec("lu_rs",      1, 5'd5, 5'd5, 5'd0, 0, 0, 0, O_STALL);
      vec("lu_clear",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_IDLE);
      vec("lu_rt",      1, 5'd7, 5'd3, 5'd7, 0, 0, 0, O_STALL);
      vec("lu_r0",      1, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_IDLE);
      vec("lu_noload",  0, 5'd5, 5'd5, 5'd5, 0, 0, 0, O_IDLE);
      vec("lu_nomatch", 1, 5'd9, 5'd8, 5'd10, 0, 0, 0, O_IDLE);
      // Memory wait with a pending taken branch: no flush until memory is ready
      for (int i = 0; i < 3; i++)
         vec($sformatf("memwait_br_%0d", i), 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, O_WAIT);
      vec("memrdy_br",   0, 5'd0, 5'd0, 5'd0, 1, 1, 1, O_FLUSH);
      vec("memwait_lu",  1, 5'd5, 5'd5, 5'd0, 0, 1, 0, O_WAIT);
      vec("br_over_lu",  1, 5'd5, 5'd5, 5'd0, 1, 0, 0, O_FLUSH);
      vec("memrdy_only", 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, O_IDLE);

      // HI/LO consumer with no multi-cycle op in flight never stalls
      @(posedge clk); #1; clear_inputs(); md_op_D = 1;
      @(negedge clk); check("mdop_idle", 32'(outs), 32'(O_IDLE));

`ifdef MULDIV_SEQ_EN
      // Multiply: busy 3 cycles, hilo_we on the 4th
      @(posedge clk); #1; clear_inputs(); md_start_E = 1;
      @(posedge clk); #1; md_start_E = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("mul_busy_%0d", k), 32'(md_busy), 32'(k < 4));
         check($sformatf("mul_we_%0d", k), 32'(hilo_we), 32'(k == 4));
      end

      // Start racing a taken branch is dropped
      @(posedge clk); #1; clear_inputs(); md_start_E = 1; pc_src_M = 1;
      @(posedge clk); #1; clear_inputs();
      begin
         int seen = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (md_busy || hilo_we) seen++;
         end
         check("race_ignored", 32'(seen), 32'd0);
      end

      // Divide with a dependent HI/LO reader waiting in DE
      @(posedge clk); #1; clear_inputs(); md_start_E = 1; md_is_div_E = 1; md_op_D = 1;
      @(posedge clk); #1; md_start_E = 0; md_is_div_E = 0;
      begin
         int busy_n = 0, stall_n = 0, we_at = -1;
         for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (md_busy) busy_n++;
            if (stall_D && flush_E) stall_n++;
            if (hilo_we && we_at < 0) we_at = k;
         end
         check("div_busy_cycles", 32'(busy_n), 32'd31);
         check("div_stall_cycles", 32'(stall_n), 32'd31);
         check("div_we_cycle", 32'(we_at), 32'd32);
      end

      // Start during BUSY: sticky error, timing unaffected
      @(posedge clk); #1; clear_inputs(); md_start_E = 1;
      @(posedge clk); #1; md_start_E = 1; md_is_div_E = 1;
      @(posedge clk); #1; clear_inputs();
      @(negedge clk); check("err_set", 32'(md_err), 32'd1);
      @(negedge clk); check("err_we_c3", 32'(hilo_we), 32'd0);
      @(negedge clk); check("err_we_c4", 32'(hilo_we), 32'd1);
      @(negedge clk); @(negedge clk);
      check("err_sticky", 32'(md_err), 32'd1);

      // Reset mid-divide
      @(posedge clk); #1; clear_inputs(); md_start_E = 1; md_is_div_E = 1;
      @(posedge clk); #1; clear_inputs();
      repeat (5) @(posedge clk);
      #3; rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(md_busy), 32'd0);
      check("rst_err", 32'(md_err), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      begin
         int we_n = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hilo_we) we_n++;
         end
         check("rst_no_we", 32'(we_n), 32'd0);
      end
`else
      // Single-cycle mul/div: hilo_we follows an accepted start directly
      @(posedge clk); #1; clear_inputs(); md_start_E = 1;
      @(negedge clk); check("sc_start", 32'(outs), 32'(9'b0000_11_010));
      @(posedge clk); #1; clear_inputs(); md_start_E = 1; md_is_div_E = 1;
      @(negedge clk); check("sc_start_div", 32'(outs), 32'(9'b0000_11_010));
      @(posedge clk); #1; clear_inputs(); md_start_E = 1; pc_src_M = 1;
      @(negedge clk); check("sc_start_br", 32'(outs), 32'(O_FLUSH));
      @(posedge clk); #1; clear_inputs(); md_start_E = 1; dm_req_M = 1;
      @(negedge clk); check("sc_start_wait", 32'(outs), 32'(O_WAIT));
      @(posedge clk); #1; clear_inputs(); md_start_E = 1; md_op_D = 1;
      @(negedge clk); check("sc_start_op", 32'(outs), 32'(9'b0000_11_010));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule
